// File: rtl/m2_fill_sched.sv
//==============================================================================
// Module   : m2_fill_sched
// Purpose  : Refills the idle bank of the M2 serializer's ping-pong word memory
//            from NREQ round-robin producers. Optional macro M2_SEQ_SLOT_EN
//            reserves word 0 of each fill for a fill sequence counter.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module m2_fill_sched #(
   parameter int                NREQ     = 4,
   parameter int                DATA_W   = 12,
   parameter int                ADDR_W   = 8,
   parameter int                TIMEOUT  = 64,
   parameter logic [DATA_W-1:0] PAD_WORD = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     iSwitch,
   input  logic [NREQ-1:0]          iValid,
   input  logic [NREQ*DATA_W-1:0]   iData,
   output logic [NREQ-1:0]          oGrant,
   output logic                     oWrEn,
   output logic [ADDR_W:0]          oWrAddr,
   output logic [DATA_W-1:0]        oWrData,
   output logic                     oBusy,
   output logic                     oFillDone,
   output logic [7:0]               oOverrunCnt
);

   localparam int c_PTR_W  = $clog2(NREQ);
   localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ARB   = 2'd1;
   localparam logic [1:0] c_WRITE = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   logic [1:0]          r_state;
   logic                r_swQ;
   logic                r_bank;
   logic [ADDR_W-1:0]   r_addr;
   logic [c_PTR_W-1:0]  r_rrPtr;
   logic [c_WAIT_W-1:0] r_waitCnt;

   logic                w_edge;
   logic                w_abort;
   logic                w_seqSlot;
   logic [DATA_W-1:0]   w_seqWord;
   logic [2*NREQ-1:0]   w_rot;
   logic                w_found;
   logic [c_PTR_W:0]    w_offset;
   logic [c_PTR_W:0]    w_sum;
   logic [c_PTR_W-1:0]  w_winner;
   logic [c_PTR_W-1:0]  w_nextPtr;
   logic [DATA_W-1:0]   w_winData;

   assign w_edge  = iSwitch ^ r_swQ;
   assign w_abort = w_edge && ((r_state == c_ARB) || (r_state == c_WRITE));

`ifdef M2_SEQ_SLOT_EN
   logic [DATA_W-1:0] r_seqCnt;

   // Counter advances at every fill start, so word 0 carries the pre-increment value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_seqCnt <= '0;
      end else if (w_edge) begin
         r_seqCnt <= r_seqCnt + DATA_W'(1);
      end
   end

   assign w_seqSlot = (r_addr == '0);
   assign w_seqWord = r_seqCnt - DATA_W'(1);
`else
   assign w_seqSlot = 1'b0;
   assign w_seqWord = '0;
`endif

   // Rotate the request vector so offset 0 is the round-robin pointer.
   always_comb begin
      w_rot    = {iValid, iValid} >> r_rrPtr;
      w_found  = 1'b0;
      w_offset = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_found  = 1'b1;
            w_offset = (c_PTR_W+1)'(k);
         end
      end
      w_sum = {1'b0, r_rrPtr} + w_offset;
      if (w_sum >= (c_PTR_W+1)'(NREQ)) begin
         w_sum = w_sum - (c_PTR_W+1)'(NREQ);
      end
      w_winner  = w_sum[c_PTR_W-1:0];
      w_nextPtr = (w_winner == c_PTR_W'(NREQ - 1)) ? '0 : w_winner + c_PTR_W'(1);
      w_winData = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_winner == c_PTR_W'(k)) begin
            w_winData = iData[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= c_IDLE;
         r_swQ       <= 1'b0;
         r_bank      <= 1'b0;
         r_addr      <= '0;
         r_rrPtr     <= '0;
         r_waitCnt   <= '0;
         oGrant      <= '0;
         oWrEn       <= 1'b0;
         oWrAddr     <= '0;
         oWrData     <= '0;
         oBusy       <= 1'b0;
         oFillDone   <= 1'b0;
         oOverrunCnt <= '0;
      end else begin
         r_swQ     <= iSwitch;
         oFillDone <= (r_state == c_DONE);
         // Any switch edge starts a fresh fill of the bank the serializer just left.
         if (w_edge) begin
            r_addr    <= '0;
            r_bank    <= ~iSwitch;
            r_waitCnt <= '0;
            oBusy     <= 1'b1;
            oWrEn     <= 1'b0;
            oGrant    <= '0;
            r_state   <= c_ARB;
            if (w_abort && (oOverrunCnt != 8'hFF)) begin
               oOverrunCnt <= oOverrunCnt + 8'd1;
            end
         end else begin
            case (r_state)
               c_IDLE: begin
                  r_state <= c_IDLE;
               end
               c_ARB: begin
                  if (w_seqSlot) begin
                     oWrEn     <= 1'b1;
                     oGrant    <= '0;
                     oWrData   <= w_seqWord;
                     oWrAddr   <= {r_bank, r_addr};
                     r_waitCnt <= '0;
                     r_state   <= c_WRITE;
                  end else if (w_found) begin
                     oWrEn     <= 1'b1;
                     oGrant    <= NREQ'(1) << w_winner;
                     oWrData   <= w_winData;
                     oWrAddr   <= {r_bank, r_addr};
                     r_rrPtr   <= w_nextPtr;
                     r_waitCnt <= '0;
                     r_state   <= c_WRITE;
                  end else if (r_waitCnt == c_WAIT_W'(TIMEOUT - 1)) begin
                     oWrEn     <= 1'b1;
                     oGrant    <= '0;
                     oWrData   <= PAD_WORD;
                     oWrAddr   <= {r_bank, r_addr};
                     r_waitCnt <= '0;
                     r_state   <= c_WRITE;
                  end else begin
                     r_waitCnt <= r_waitCnt + c_WAIT_W'(1);
                  end
               end
               c_WRITE: begin
                  oWrEn  <= 1'b0;
                  oGrant <= '0;
                  if (r_addr == '1) begin
                     r_state <= c_DONE;
                  end else begin
                     r_addr  <= r_addr + ADDR_W'(1);
                     r_state <= c_ARB;
                  end
               end
               c_DONE: begin
                  oBusy   <= 1'b0;
                  r_state <= c_IDLE;
               end
               default: begin
                  r_state <= c_IDLE;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_m2_fill_sched.sv
//==============================================================================
// Module   : tb_m2_fill_sched
// Purpose  : Self-checking bench for m2_fill_sched (table of fill scenarios,
//            random fills, overrun, saturation and mid-fill reset).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_m2_fill_sched;

   localparam int         NREQ    = 4;
   localparam int         DATA_W  = 12;
   localparam int         ADDR_W  = 8;
   localparam int         TIMEOUT = 64;
   localparam logic [11:0] PAD    = 12'h000;
   localparam int         WORDS   = 256;
`ifdef M2_SEQ_SLOT_EN
   localparam int SEQ = 1;
`else
   localparam int SEQ = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        iSwitch;
   logic [3:0]  iValid;
   logic [47:0] iData;
   logic [3:0]  oGrant;
   logic        oWrEn;
   logic [8:0]  oWrAddr;
   logic [11:0] oWrData;
   logic        oBusy;
   logic        oFillDone;
   logic [7:0]  oOverrunCnt;

   m2_fill_sched #(
      .NREQ     (NREQ),
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .TIMEOUT  (TIMEOUT),
      .PAD_WORD (PAD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .iSwitch     (iSwitch),
      .iValid      (iValid),
      .iData       (iData),
      .oGrant      (oGrant),
      .oWrEn       (oWrEn),
      .oWrAddr     (oWrAddr),
      .oWrData     (oWrData),
      .oBusy       (oBusy),
      .oFillDone   (oFillDone),
      .oOverrunCnt (oOverrunCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mask;
      bit         randData;
      logic [3:0] expFirstGrant;
      logic       expBank;
   } fillRow_t;

   int          nChecks   = 0;
   int          nFails    = 0;
   int          modelPtr  = 0;
   int          ovModel   = 0;
   int          seqStarts = 0;
   logic [11:0] cur [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Next producer in cyclic order starting from pointer p; -1 if none valid.
   function automatic int rrPick(input logic [3:0] m, input int p);
      int j;
      for (int k = 0; k < NREQ; k++) begin
         j = (p + k) % NREQ;
         if (m[j[1:0]]) return j;
      end
      return -1;
   endfunction

   task automatic driveData();
      iData = {cur[3], cur[2], cur[1], cur[0]};
   endtask

   task automatic runFill(input fillRow_t r, input bit toggle, input int abortAt, input bit chkRow);
      int          expAddr, cycles, w, expSeq, abortPt;
      bit          done, aborted, seenFirst;
      logic        expBank;
      logic [11:0] eData;
      logic [3:0]  eGrant;
      iValid = r.mask;
      for (int i = 0; i < NREQ; i++) cur[i] = r.randData ? 12'($urandom) : 12'hABC;
      driveData();
      if (toggle) iSwitch = ~iSwitch;
      expBank   = ~iSwitch;
      expAddr   = 0;
      cycles    = 0;
      done      = 1'b0;
      aborted   = 1'b0;
      seenFirst = 1'b0;
      abortPt   = abortAt;
      expSeq    = seqStarts;
      seqStarts++;
      while (!done && cycles < 20000) begin
         @(negedge clk);
         cycles++;
         if (oWrEn) begin
            w = -1;
            if (SEQ != 0 && expAddr == 0) begin
               eData  = 12'(expSeq);
               eGrant = 4'b0000;
            end else begin
               w = rrPick(r.mask, modelPtr);
               if (w < 0) begin
                  eData  = PAD;
                  eGrant = 4'b0000;
               end else begin
                  eData  = cur[w];
                  eGrant = 4'(1) << w;
               end
            end
            check("write", {oBusy, oWrAddr, oWrData, oGrant}, {1'b1, expBank, 8'(expAddr), eData, eGrant});
            if (chkRow && !seenFirst && (SEQ == 0 || expAddr != 0)) begin
               seenFirst = 1'b1;
`ifndef M2_SEQ_SLOT_EN
               check("firstGrant", oGrant, r.expFirstGrant);
`endif
               check("bank", oWrAddr[8], r.expBank);
            end
            if (w >= 0) begin
               modelPtr = (w + 1) % NREQ;
               cur[w]   = r.randData ? 12'($urandom) : 12'hABC;
               driveData();
            end
            if (expAddr == abortPt) begin
               iSwitch   = ~iSwitch;
               expBank   = ~iSwitch;
               expAddr   = 0;
               aborted   = 1'b1;
               abortPt   = -1;
               ovModel   = (ovModel < 255) ? ovModel + 1 : 255;
               expSeq    = seqStarts;
               seqStarts++;
            end else begin
               expAddr++;
            end
         end
         if (oFillDone) begin
            done = 1'b1;
            check("fillDoneAfterLastWord", expAddr, WORDS);
         end
      end
      check("fillDoneWithinBudget", done, 1);
      check("overrunCnt", oOverrunCnt, ovModel);
      check("busyClearedAtDone", oBusy, 0);
      if (!aborted) check("fillCycles", cycles, 2 + ((r.mask == 4'b0000) ? TIMEOUT + 1 : 2) * WORDS);
   endtask

   initial begin
      fillRow_t rows [6];
      fillRow_t row;
      bit       anyWrite;
      int       waitCyc;

      rows[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0};
      rows[1] = '{4'b0100, 1'b0, 4'b0100, 1'b1};
      rows[2] = '{4'b0011, 1'b1, 4'b0001, 1'b0};
      rows[3] = '{4'b1010, 1'b1, 4'b1000, 1'b1};
      rows[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
      rows[5] = '{4'b1101, 1'b1, 4'b0100, 1'b1};

      reset   = 1'b0;
      iSwitch = 1'b0;
      iValid  = 4'b0000;
      iData   = '0;
      repeat (3) @(negedge clk);
      check("resetOutputs", {oGrant, oWrEn, oWrAddr, oWrData, oBusy, oFillDone, oOverrunCnt}, 0);
      reset = 1'b1;
      @(negedge clk);
      check("idleAfterRelease", {oBusy, oWrEn, oFillDone}, 0);

      for (int i = 0; i < 6; i++) runFill(rows[i], 1'b1, -1, 1'b1);

      for (int i = 0; i < 3; i++) begin
         row = '{4'($urandom_range(1, 15)), 1'b1, 4'b0000, 1'b0};
         runFill(row, 1'b1, -1, 1'b0);
      end

      row = '{4'b1111, 1'b1, 4'b0000, 1'b0};
      runFill(row, 1'b1, 100, 1'b0);

      // Switch every cycle: each edge after the first aborts a fill before any grant.
      iValid   = 4'b1111;
      anyWrite = 1'b0;
      for (int n = 0; n < 260; n++) begin
         @(negedge clk);
         if (oWrEn) anyWrite = 1'b1;
         iSwitch = ~iSwitch;
         seqStarts++;
         if (n > 0) ovModel = (ovModel < 255) ? ovModel + 1 : 255;
      end
      @(negedge clk);
      check("noWriteWhileToggling", anyWrite, 0);
      check("overrunSaturated", oOverrunCnt, ovModel);

      waitCyc = 0;
      while (!oWrEn && waitCyc < 10) begin
         @(negedge clk);
         waitCyc++;
      end
      check("writeBeforeReset", oWrEn, 1);
      reset = 1'b0;
      #1;
      check("asyncClear", {oWrEn, oGrant, oBusy, oOverrunCnt}, 0);
      iSwitch = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check("heldInReset", {oWrEn, oBusy, oFillDone}, 0);
      end
      reset     = 1'b1;
      modelPtr  = 0;
      ovModel   = 0;
      seqStarts = 0;
      row = '{4'b1111, 1'b1, 4'b0001, 1'b0};
      runFill(row, 1'b0, -1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

`default_nettype wire
